// File: rtl/slc3_panel_input_pkg.sv
// Shared types and constants for the SLC-3 front-panel input conditioning.
package slc3_panel_pkg;

  localparam int unsigned DEFAULT_DEBOUNCE = 500000;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_CHK,
    HELD,
    REL_CHK
  } key_state_t;

endpackage

// File: rtl/slc3_panel_input_if.sv
// Per-key bundle: raw active-low key in, debounced level and press strobe out.
interface slc3_panel_input_if;

  logic key_n;
  logic db_n;
  logic pulse;

  modport master (output key_n, input db_n, input pulse);
  modport slave  (input key_n, output db_n, output pulse);

endinterface

// File: rtl/slc3_panel_input_key_debounce.sv
// One key: two-flop synchronizer, press/release debounce FSM, one-shot press strobe.
module key_debounce
  import slc3_panel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic               clk,
  input  logic               rst,
  slc3_panel_input_if.slave  key
);

  localparam int unsigned    CW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  key_state_t    state;
  logic [CW-1:0] cnt;
  logic          db_n_q;
  logic          pulse_q;

  // The counter stops at CNT_MAX; the transition fires on the cycle it is seen there.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      state   <= IDLE;
      cnt     <= '0;
      db_n_q  <= 1'b1;
      pulse_q <= 1'b0;
    end else begin
      sync1   <= key.key_n;
      sync2   <= sync1;
      pulse_q <= 1'b0;
      case (state)
        IDLE: begin
          if (!sync2) begin
            state <= PRESS_CHK;
            cnt   <= '0;
          end
        end
        PRESS_CHK: begin
          if (sync2) begin
            state <= IDLE;
          end else if (cnt == CNT_MAX) begin
            state   <= HELD;
            db_n_q  <= 1'b0;
            pulse_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HELD: begin
          if (sync2) begin
            state <= REL_CHK;
            cnt   <= '0;
          end
        end
        REL_CHK: begin
          if (!sync2) begin
            state <= HELD;
          end else if (cnt == CNT_MAX) begin
            state  <= IDLE;
            db_n_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign key.db_n  = db_n_q;
  assign key.pulse = pulse_q;

endmodule

// File: rtl/slc3_panel_input.sv
// Front-panel input block: debounced Run/Continue keys and synchronized slide switches.
module slc3_panel_input
  import slc3_panel_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Run_n,
  input  logic       Continue_n,
  input  logic [9:0] SW,
  output logic [9:0] SW_sync,
  output logic       Run_db_n,
  output logic       Continue_db_n,
  output logic       Run_pulse,
  output logic       Continue_pulse
);

  slc3_panel_input_if run_key ();
  slc3_panel_input_if cont_key ();

  logic [9:0] sw_meta;
  logic [9:0] sw_q;

  assign run_key.key_n  = Run_n;
  assign cont_key.key_n = Continue_n;
  assign Run_db_n       = run_key.db_n;
  assign Run_pulse      = run_key.pulse;
  assign Continue_db_n  = cont_key.db_n;
  assign Continue_pulse = cont_key.pulse;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run_key (
    .clk (Clk),
    .rst (Reset),
    .key (run_key)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_cont_key (
    .clk (Clk),
    .rst (Reset),
    .key (cont_key)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      sw_meta <= '0;
      sw_q    <= '0;
    end else begin
      sw_meta <= SW;
      sw_q    <= sw_meta;
    end
  end

  assign SW_sync = sw_q;

endmodule

// File: tb/tb_slc3_panel_input.sv
// Directed bench for slc3_panel_input with a run-length debounce model checked every cycle.
module tb_slc3_panel_input;

  localparam int unsigned N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] sw  = '0;
  logic [9:0] sw_sync;

  slc3_panel_input_if run_bus ();
  slc3_panel_input_if cont_bus ();

  slc3_panel_input #(.DEBOUNCE_CYCLES(N)) dut (
    .Clk            (clk),
    .Reset          (rst),
    .Run_n          (run_bus.key_n),
    .Continue_n     (cont_bus.key_n),
    .SW             (sw),
    .SW_sync        (sw_sync),
    .Run_db_n       (run_bus.db_n),
    .Continue_db_n  (cont_bus.db_n),
    .Run_pulse      (run_bus.pulse),
    .Continue_pulse (cont_bus.pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s at cycle %0d: got %0h, want %0h", name, cyc, act, exp);
  endtask

  // Model: a key's level flips once the synchronized input has disagreed with it
  // for N+2 consecutive samples; synchronized input is the raw value two edges old.
  logic       kh0 [2];
  logic       kh1 [2];
  logic       kdb [2];
  logic       kpulse [2];
  int         krun [2];
  logic       raw [2];
  logic       y;
  logic [9:0] swh0, swh1;
  bit         model_live = 1'b0;

  always @(posedge clk) begin
    raw[0] = run_bus.key_n;
    raw[1] = cont_bus.key_n;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        kh0[k] = 1'b1; kh1[k] = 1'b1; kdb[k] = 1'b1; krun[k] = 0; kpulse[k] = 1'b0;
      end else begin
        y = kh1[k];
        kh1[k] = kh0[k];
        kh0[k] = raw[k];
        kpulse[k] = 1'b0;
        if (y != kdb[k]) begin
          krun[k]++;
          if (krun[k] == int'(N) + 2) begin
            kdb[k] = y;
            krun[k] = 0;
            kpulse[k] = !y;
          end
        end else begin
          krun[k] = 0;
        end
      end
    end
    if (rst) begin
      swh0 = '0; swh1 = '0;
    end else begin
      swh1 = swh0; swh0 = sw;
    end
    model_live = 1'b1;
  end

  always @(negedge clk) begin
    if (model_live) begin
      chk("model_run_db_n",  run_bus.db_n,   kdb[0]);
      chk("model_run_pulse", run_bus.pulse,  kpulse[0]);
      chk("model_cont_db_n", cont_bus.db_n,  kdb[1]);
      chk("model_cont_pulse",cont_bus.pulse, kpulse[1]);
      chk("model_sw_sync",   sw_sync,        swh1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want finish");
    $fatal(1);
  end

  initial begin
    run_bus.key_n  = 1'b1;
    cont_bus.key_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_run_db_n",   run_bus.db_n,   1);
    chk("reset_cont_db_n",  cont_bus.db_n,  1);
    chk("reset_run_pulse",  run_bus.pulse,  0);
    chk("reset_cont_pulse", cont_bus.pulse, 0);
    chk("reset_sw_sync",    sw_sync,        0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Switches: two-cycle latency
    sw = 10'h09C;
    @(negedge clk); chk("sw_after_1", sw_sync, 10'h000);
    @(negedge clk); chk("sw_after_2", sw_sync, 10'h09C);

    // Clean press held 20 cycles
    run_bus.key_n = 1'b0;
    repeat (7) @(negedge clk);
    chk("clean_pre_pulse", run_bus.pulse, 0);
    @(negedge clk);
    chk("clean_pulse", run_bus.pulse, 1);
    chk("clean_db_n", run_bus.db_n, 0);
    @(negedge clk);
    chk("clean_pulse_end", run_bus.pulse, 0);
    repeat (11) begin
      @(negedge clk);
      chk("clean_held_db_n", run_bus.db_n, 0);
    end
    run_bus.key_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("clean_released", run_bus.db_n, 1);

    // Bounce: 2-cycle toggles for 12 cycles, then stable low
    for (int i = 0; i < 12; i++) begin
      run_bus.key_n = ((i / 2) % 2) != 0;
      @(negedge clk);
      chk("bounce_no_pulse", run_bus.pulse, 0);
    end
    run_bus.key_n = 1'b0;
    repeat (7) begin
      @(negedge clk);
      chk("bounce_settle_no_pulse", run_bus.pulse, 0);
    end
    @(negedge clk);
    chk("bounce_pulse", run_bus.pulse, 1);
    run_bus.key_n = 1'b1;
    repeat (10) @(negedge clk);

    // Release glitch on Continue while held
    cont_bus.key_n = 1'b0;
    repeat (8) @(negedge clk);
    chk("glitch_first_pulse", cont_bus.pulse, 1);
    cont_bus.key_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("glitch_db_n_high", cont_bus.db_n, 0);
    end
    cont_bus.key_n = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("glitch_db_n", cont_bus.db_n, 0);
      chk("glitch_no_pulse", cont_bus.pulse, 0);
    end
    cont_bus.key_n = 1'b1;
    repeat (10) @(negedge clk);

    // Simultaneous press
    run_bus.key_n  = 1'b0;
    cont_bus.key_n = 1'b0;
    repeat (7) @(negedge clk);
    @(negedge clk);
    chk("simul_run_pulse",  run_bus.pulse,  1);
    chk("simul_cont_pulse", cont_bus.pulse, 1);
    run_bus.key_n  = 1'b1;
    cont_bus.key_n = 1'b1;
    repeat (10) @(negedge clk);

    // Reset three cycles into the pending press, key kept low
    run_bus.key_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("rstmid_no_pulse_before", run_bus.pulse, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_db_n",    run_bus.db_n,  1);
    chk("rstmid_pulse",   run_bus.pulse, 0);
    chk("rstmid_sw_sync", sw_sync,       10'h000);
    rst = 1'b0;
    repeat (7) begin
      @(negedge clk);
      chk("rstmid_no_pulse_after", run_bus.pulse, 0);
    end
    @(negedge clk);
    chk("rstmid_pulse_after", run_bus.pulse, 1);
    run_bus.key_n = 1'b1;
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
